// File: rtl/axi4_lite_bram_slave.sv
// axi4_lite_bram_slave
//   AXI4-Lite slave in front of an inferred single-port block RAM. Only one
//   transaction is in flight at a time. A write is accepted only when address
//   and data are both valid. When a read and a write are requested in the
//   same idle cycle, they are granted alternately.
//
//   Optional feature macro: AXIL_RANGE_CHECK_EN
//     defined   : accesses outside [BASE_ADDR, BASE_ADDR + BRAM_DEPTH*DATA_W/8)
//                 get SLVERR. Such writes are dropped and such reads return 0.
//     undefined : the word index wraps modulo BRAM_DEPTH. Every response is OKAY.
//
// Ports
//   ACLK, ARESET                    clock, synchronous active-high reset
//   AW_VALID/AW_READY/AW_ADDR       write address channel
//   W_VALID/W_READY/W_DATA/W_STRB   write data channel with byte enables
//   B_VALID/B_READY/B_RESP          write response channel
//   AR_VALID/AR_READY/AR_ADDR       read address channel
//   R_VALID/R_READY/R_DATA/R_RESP   read data channel
//
// State table
//   state       | meaning
//   S_IDLE      | no transaction in flight, arbitrate AW+W against AR
//   S_WR_RESP   | write committed, B_VALID held until B_READY
//   S_RD_RESP   | read data registered, R_VALID held until R_READY

module axi4_lite_bram_slave #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                BRAM_DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                BRAM_ADDR_W = $clog2(BRAM_DEPTH)
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                AW_VALID,
  output logic                AW_READY,
  input  logic [ADDR_W-1:0]   AW_ADDR,
  input  logic                W_VALID,
  output logic                W_READY,
  input  logic [DATA_W-1:0]   W_DATA,
  input  logic [DATA_W/8-1:0] W_STRB,
  output logic                B_VALID,
  input  logic                B_READY,
  output logic [1:0]          B_RESP,
  input  logic                AR_VALID,
  output logic                AR_READY,
  input  logic [ADDR_W-1:0]   AR_ADDR,
  output logic                R_VALID,
  input  logic                R_READY,
  output logic [DATA_W-1:0]   R_DATA,
  output logic [1:0]          R_RESP
);

  localparam int STRB_W = DATA_W / 8;
  localparam int BYTE_W = $clog2(STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_RESP = 2'd1,
    S_RD_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [BRAM_DEPTH];

  logic [ADDR_W-1:0]      wr_off, rd_off;
  logic [BRAM_ADDR_W-1:0] wr_idx, rd_idx;
  logic                   wr_ok, rd_ok;
  logic                   prio_rd;
  logic                   idle, wr_req, rd_req, grant_wr, grant_rd;

  logic                   b_valid_q, r_valid_q;
  logic [1:0]             b_resp_q, r_resp_q;
  logic [DATA_W-1:0]      r_data_q;

  // Address decode. The shift drops the byte-lane bits. The cast drops
  // the bits above the index, which gives the wrap-around behaviour.
  assign wr_off = AW_ADDR - BASE_ADDR;
  assign rd_off = AR_ADDR - BASE_ADDR;
  assign wr_idx = BRAM_ADDR_W'(wr_off >> BYTE_W);
  assign rd_idx = BRAM_ADDR_W'(rd_off >> BYTE_W);

`ifdef AXIL_RANGE_CHECK_EN
  // The extra top bit keeps the span from overflowing when the memory
  // covers the whole address space.
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(BRAM_DEPTH * STRB_W);
  assign wr_ok = (AW_ADDR >= BASE_ADDR) && ({1'b0, wr_off} < SPAN);
  assign rd_ok = (AR_ADDR >= BASE_ADDR) && ({1'b0, rd_off} < SPAN);
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  // Arbitration. A grant is possible only in idle and outside reset. When
  // both sides request, prio_rd decides which one wins. prio_rd flips on
  // every grant.
  assign idle     = (state == S_IDLE) && !ARESET;
  assign wr_req   = AW_VALID && W_VALID;
  assign rd_req   = AR_VALID;
  assign grant_rd = idle && rd_req && (prio_rd || !wr_req);
  assign grant_wr = idle && wr_req && !grant_rd;

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_wr)      state_nxt = S_WR_RESP;
        else if (grant_rd) state_nxt = S_RD_RESP;
      end
      S_WR_RESP: if (b_valid_q && B_READY) state_nxt = S_IDLE;
      S_RD_RESP: if (r_valid_q && R_READY) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    AW_READY = grant_wr;
    W_READY  = grant_wr;
    AR_READY = grant_rd;
    B_VALID  = b_valid_q;
    B_RESP   = b_resp_q;
    R_VALID  = r_valid_q;
    R_RESP   = r_resp_q;
    R_DATA   = r_data_q;
  end

  // Response registers and the arbitration flag.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      r_valid_q <= 1'b0;
      r_resp_q  <= RESP_OKAY;
      r_data_q  <= '0;
      prio_rd   <= 1'b1;
    end else begin
      if (grant_wr) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (b_valid_q && B_READY) begin
        b_valid_q <= 1'b0;
        b_resp_q  <= RESP_OKAY;
      end

      if (grant_rd) begin
        r_valid_q <= 1'b1;
        r_resp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        r_data_q  <= rd_ok ? mem[rd_idx] : '0;
      end else if (r_valid_q && R_READY) begin
        r_valid_q <= 1'b0;
        r_resp_q  <= RESP_OKAY;
      end

      if (grant_wr || grant_rd) prio_rd <= ~prio_rd;
    end
  end

  // Byte-lane writes. The memory has no reset, so its contents survive
  // ARESET.
  always_ff @(posedge ACLK) begin
    if (grant_wr && wr_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (W_STRB[i]) mem[wr_idx][i*8 +: 8] <= W_DATA[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_bram_slave.sv
module tb_axi4_lite_bram_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AW_VALID, AW_READY;
  logic [31:0] AW_ADDR;
  logic        W_VALID, W_READY;
  logic [31:0] W_DATA;
  logic [3:0]  W_STRB;
  logic        B_VALID, B_READY;
  logic [1:0]  B_RESP;
  logic        AR_VALID, AR_READY;
  logic [31:0] AR_ADDR;
  logic        R_VALID, R_READY;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] model [1024];

  always #5 ACLK = ~ACLK;

  axi4_lite_bram_slave #(
    .DATA_W(32), .ADDR_W(32), .BRAM_DEPTH(1024), .BASE_ADDR(32'h0)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  // Reference model: the memory is an array of words, decoded as byte address / 4
  function automatic bit out_of_range(input logic [31:0] a);
`ifdef AXIL_RANGE_CHECK_EN
    return a >= 32'h1000;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % 1024);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    if (!out_of_range(a))
      for (int i = 0; i < 4; i++)
        if (s[i]) model[word_of(a)][i*8 +: 8] = d[i*8 +: 8];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return out_of_range(a) ? 32'h0 : model[word_of(a)];
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return out_of_range(a) ? 2'b10 : 2'b00;
  endfunction

  task automatic apply_reset();
    ARESET = 1'b1;
    AW_VALID = 0; W_VALID = 0; AR_VALID = 0; B_READY = 0; R_READY = 0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got = 0;
    AW_ADDR = a; W_DATA = d; W_STRB = s;
    AW_VALID = 1; W_VALID = 1; B_READY = 1;
    for (int n = 0; n < 20 && !got; n++) begin
      #2 if (AW_READY && W_READY) got = 1;
      @(posedge ACLK); #1;
    end
    AW_VALID = 0; W_VALID = 0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL wr_grant addr=%h: no AW/W handshake within 20 cycles", a);
    end
    if (got) model_write(a, d, s);
    vectors++;
    if (B_VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL b_valid addr=%h: got %b want 1", a, B_VALID);
    end
    vectors++;
    if (B_RESP !== model_resp(a)) begin
      miscompares++;
      $display("FAIL b_resp addr=%h: got %b want %b", a, B_RESP, model_resp(a));
    end
    @(posedge ACLK); #1;
    B_READY = 0;
    vectors++;
    if (B_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL b_drop addr=%h: got %b want 0", a, B_VALID);
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    bit got = 0;
    AR_ADDR = a; AR_VALID = 1; R_READY = 1;
    for (int n = 0; n < 20 && !got; n++) begin
      #2 if (AR_READY) got = 1;
      @(posedge ACLK); #1;
    end
    AR_VALID = 0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL rd_grant addr=%h: no AR handshake within 20 cycles", a);
    end
    d = R_DATA;
    vectors++;
    if (R_VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL r_latency addr=%h: r_valid got %b want 1", a, R_VALID);
    end
    vectors++;
    if (R_DATA !== model_read(a)) begin
      miscompares++;
      $display("FAIL r_data addr=%h: got %h want %h", a, R_DATA, model_read(a));
    end
    vectors++;
    if (R_RESP !== model_resp(a)) begin
      miscompares++;
      $display("FAIL r_resp addr=%h: got %b want %b", a, R_RESP, model_resp(a));
    end
    @(posedge ACLK); #1;
    R_READY = 0;
    vectors++;
    if (R_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL r_drop addr=%h: got %b want 0", a, R_VALID);
    end
  endtask

  task automatic test_reset();
    ARESET = 1; B_READY = 0; R_READY = 0;
    AW_VALID = 1; W_VALID = 1; AR_VALID = 1;
    AW_ADDR = 0; AR_ADDR = 0; W_DATA = 0; W_STRB = 0;
    @(posedge ACLK); @(posedge ACLK); #1;
    vectors++;
    if ({B_VALID, R_VALID} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_valid: got b=%b r=%b want 0 0", B_VALID, R_VALID);
    end
    vectors++;
    if ({B_RESP, R_RESP} !== 4'b0000 || R_DATA !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_resp: got b=%b r=%b data=%h want 0", B_RESP, R_RESP, R_DATA);
    end
    vectors++;
    if ({AW_READY, W_READY, AR_READY} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 000", {AW_READY, W_READY, AR_READY});
    end
    AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
    @(posedge ACLK); #1 ARESET = 0;
  endtask

  task automatic test_init();
    for (int w = 0; w < 16; w++) do_write(32'(w * 4), $urandom, 4'hF);
  endtask

  task automatic test_basic();
    logic [31:0] d;
    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    do_read(32'h10, d);
    vectors++;
    if (d !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL basic_rd: got %h want deadbeef", d);
    end
    do_write(32'h10, 32'h11223344, 4'b0101);
    do_read(32'h10, d);
    vectors++;
    if (d !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL strb_rd: got %h want de22be44", d);
    end
    do_write(32'h10, 32'hFFFFFFFF, 4'h0);
    do_read(32'h13, d);
    vectors++;
    if (d !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL strb0_rd: got %h want de22be44", d);
    end
  endtask

  task automatic test_aw_early();
    AW_ADDR = 32'h20; AW_VALID = 1; W_VALID = 0; AR_VALID = 0; B_READY = 1;
    repeat (3) begin
      #2;
      vectors++;
      if ({AW_READY, W_READY} !== 2'b00) begin
        miscompares++;
        $display("FAIL aw_early_ready: got %b want 00", {AW_READY, W_READY});
      end
      @(posedge ACLK); #1;
    end
    W_DATA = 32'hA5A51234; W_STRB = 4'hF; W_VALID = 1;
    #2;
    vectors++;
    if ({AW_READY, W_READY} !== 2'b11) begin
      miscompares++;
      $display("FAIL aw_join_ready: got %b want 11", {AW_READY, W_READY});
    end
    @(posedge ACLK); #1;
    AW_VALID = 0; W_VALID = 0;
    model_write(32'h20, 32'hA5A51234, 4'hF);
    vectors++;
    if (B_VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL aw_join_b: got %b want 1", B_VALID);
    end
    repeat (3) begin
      @(posedge ACLK); #1;
      vectors++;
      if (B_VALID !== 1'b0) begin
        miscompares++;
        $display("FAIL aw_single_b: got %b want 0", B_VALID);
      end
    end
    B_READY = 0;
  endtask

  task automatic test_arbitration();
    byte order [$];
    byte want [4] = '{"R", "W", "R", "W"};
    apply_reset();
    AW_ADDR = 32'h40; W_DATA = 32'h0BADCAFE; W_STRB = 4'hF; AR_ADDR = 32'h44;
    AW_VALID = 1; W_VALID = 1; AR_VALID = 1; B_READY = 1; R_READY = 1;
    for (int n = 0; n < 40 && order.size() < 4; n++) begin
      #2;
      if (AR_READY) order.push_back("R");
      if (AW_READY && W_READY) begin
        order.push_back("W");
        model_write(32'h40, 32'h0BADCAFE, 4'hF);
      end
      @(posedge ACLK); #1;
    end
    AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
    repeat (2) @(posedge ACLK);
    #1 B_READY = 0; R_READY = 0;
    vectors++;
    if (order.size() !== 4) begin
      miscompares++;
      $display("FAIL arb_count: got %0d grants want 4", order.size());
    end
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      vectors++;
      if (order[i] !== want[i]) begin
        miscompares++;
        $display("FAIL arb_order[%0d]: got %s want %s", i, order[i], want[i]);
      end
    end
  endtask

  task automatic test_rready_stall();
    logic [31:0] exp_d;
    exp_d = model_read(32'h10);
    AR_ADDR = 32'h10; AR_VALID = 1; R_READY = 0;
    #2;
    vectors++;
    if (AR_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_ar_grant: got %b want 1", AR_READY);
    end
    @(posedge ACLK); #1;
    AR_ADDR = 32'h14;
    repeat (5) begin
      #2;
      vectors++;
      if (R_VALID !== 1'b1 || R_DATA !== exp_d || AR_READY !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: got v=%b d=%h ar=%b want 1 %h 0",
                 R_VALID, R_DATA, AR_READY, exp_d);
      end
      @(posedge ACLK); #1;
    end
    AR_VALID = 0; R_READY = 1;
    @(posedge ACLK); #1;
    R_READY = 0;
    vectors++;
    if (R_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_drop: got %b want 0", R_VALID);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    do_read(32'h1000, d);
    do_write(32'h1004, 32'hCAFEF00D, 4'hF);
    do_read(32'h4, d);
    do_read(32'h1004, d);
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a + 32'h1000;
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)));
      else                           do_read(a, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    AW_ADDR = 32'h30; W_DATA = 32'h600DF00D; W_STRB = 4'hF;
    AW_VALID = 1; W_VALID = 1; B_READY = 0;
    #2;
    vectors++;
    if ({AW_READY, W_READY} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_mid_grant: got %b want 11", {AW_READY, W_READY});
    end
    @(posedge ACLK); #1;
    AW_VALID = 0; W_VALID = 0;
    model_write(32'h30, 32'h600DF00D, 4'hF);
    @(posedge ACLK); #1;
    vectors++;
    if (B_VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_hold: got %b want 1", B_VALID);
    end
    ARESET = 1;
    @(posedge ACLK); #1;
    vectors++;
    if (B_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_drop: got %b want 0", B_VALID);
    end
    ARESET = 0;
    @(posedge ACLK); #1;
    do_read(32'h30, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    AW_ADDR = 0; AR_ADDR = 0; W_DATA = 0; W_STRB = 0;
    test_reset();
    test_init();
    test_basic();
    test_aw_early();
    test_arbitration();
    test_rready_stall();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
